// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, ALU operations, condition codes and the data-processing decoder.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch
  } mc_state_e;

  // ALUControl
  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOrr = 4'b0011;

  // ResultSrc
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // Op field
  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;
  localparam logic [1:0] OpNop = 2'b11;

  // Data-processing cmd field
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  // Condition codes
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       no_write;  // result is not written back
    logic       force_s;   // flags update regardless of the S bit
    logic       flag_upd;  // command is allowed to touch flags at all
    logic       nz_only;   // logical op: C and V hold
  } dp_dec_t;

  function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
    dp_dec_t d;
    d = '{alu_ctl: AluAdd, no_write: 1'b1, force_s: 1'b0, flag_upd: 1'b0, nz_only: 1'b0};
    case (cmd)
      CmdAdd: d = '{alu_ctl: AluAdd, no_write: 1'b0, force_s: 1'b0, flag_upd: 1'b1,
                    nz_only: 1'b0};
      CmdSub: d = '{alu_ctl: AluSub, no_write: 1'b0, force_s: 1'b0, flag_upd: 1'b1,
                    nz_only: 1'b0};
      CmdAnd: d = '{alu_ctl: AluAnd, no_write: 1'b0, force_s: 1'b0, flag_upd: 1'b1,
                    nz_only: 1'b1};
      CmdOrr: d = '{alu_ctl: AluOrr, no_write: 1'b0, force_s: 1'b0, flag_upd: 1'b1,
                    nz_only: 1'b1};
      CmdCmp: d = '{alu_ctl: AluSub, no_write: 1'b1, force_s: 1'b1, flag_upd: 1'b1,
                    nz_only: 1'b0};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_condcheck.sv
// Combinational condition evaluation: ARM condition field against {N,Z,C,V}.
module arm_condcheck
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Decode the condition field into a single execute qualifier.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      CondEq:  cond_ex_o = z;
      CondNe:  cond_ex_o = ~z;
      CondCs:  cond_ex_o = c;
      CondCc:  cond_ex_o = ~c;
      CondMi:  cond_ex_o = n;
      CondPl:  cond_ex_o = ~n;
      CondVs:  cond_ex_o = v;
      CondVc:  cond_ex_o = ~v;
      CondHi:  cond_ex_o = c & ~z;
      CondLs:  cond_ex_o = ~c | z;
      CondGe:  cond_ex_o = (n == v);
      CondLt:  cond_ex_o = (n != v);
      CondGt:  cond_ex_o = ~z & (n == v);
      CondLe:  cond_ex_o = z | (n != v);
      CondAl:  cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;  // CondNv
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing the shared memory and ALU,
// plus the flags register and the CondEx register sampled in DECODE.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc
);

  // Instr holds Instr[31:12] of the architectural instruction.
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];

  // Rn and Rd are routed by the datapath, not used here.
  logic unused_regs;
  assign unused_regs = ^Instr[7:0];

  mc_state_e  state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;
  dp_dec_t    dec;

  arm_condcheck u_condcheck (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  assign dec    = dp_decode(funct[4:1]);
  assign ImmSrc = op;
  assign RegSrc = {op == OpMem, op == OpBr};

  // State, flags and CondEx registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // CondEx is captured only at the end of DECODE; flags only at the end of execute.
  always_comb begin
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    if (state_q == StDecode) begin
      cond_ex_d = cond_ex;
    end
    if ((state_q == StExecR || state_q == StExecI) && cond_ex_q && dec.flag_upd &&
        (funct[0] || dec.force_s)) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (!dec.nz_only) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpMem:   state_d = StMemAdr;
          OpDp:    state_d = funct[5] ? StExecI : StExecR;
          OpBr:    state_d = StBranch;
          default: state_d = StFetch;  // OpNop
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Moore outputs; reset forces enables off and selects to their FETCH values.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = ResAluOut;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBRd2;
    ALUControl = AluAdd;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StMemAdr: ALUSrcB = SrcBImm;
      StMemRd:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = cond_ex_q;
      end
      StMemWr: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
      end
      StExecR: ALUControl = dec.alu_ctl;
      StExecI: begin
        ALUSrcB    = SrcBImm;
        ALUControl = dec.alu_ctl;
      end
      StAluWb: RegWrite = cond_ex_q & ~dec.no_write;
      StBranch: begin
        ALUSrcB   = SrcBImm;
        ResultSrc = ResAluResult;
        PCWrite   = cond_ex_q;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = ResAluResult;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SrcBFour;
      ALUControl = AluAdd;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: checks control outputs every cycle of
// hand-built instruction sequences against the per-state output table.
module tb_arm_mc_controller;

  typedef enum {TFetch, TDecode, TMemAdr, TMemRd, TMemWb, TMemWr, TExecR, TExecI, TAluWb,
                TBranch} tst_e;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  ALUControl;

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
  logic [13:0] ctl;
  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl};

  localparam logic [13:0] MBase = 14'b1_0_1_1_1_00_0_00_1111;
  localparam logic [13:0] MAdr  = 14'b0_1_0_0_0_00_0_00_0000;
  localparam logic [13:0] MRs   = 14'b0_0_0_0_0_11_0_00_0000;
  localparam logic [13:0] MA    = 14'b0_0_0_0_0_00_1_00_0000;
  localparam logic [13:0] MB    = 14'b0_0_0_0_0_00_0_11_0000;
  localparam logic [13:0] RstVec = 14'b0_0_0_0_0_10_1_10_0000;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] care_of(input tst_e s);
    case (s)
      TFetch:                    return MBase | MAdr | MRs | MA | MB;
      TDecode, TBranch:          return MBase | MRs | MA | MB;
      TMemAdr, TExecR, TExecI:   return MBase | MA | MB;
      TMemRd, TMemWr:            return MBase | MAdr;
      default:                   return MBase | MRs;  // TMemWb, TAluWb
    endcase
  endfunction

  // Selects the state table specifies, as {adr, rs, a, b} placed in the ctl layout.
  function automatic logic [13:0] sel_of(input tst_e s);
    case (s)
      TFetch, TDecode: return {1'b0, 1'b0, 3'b000, 2'b10, 1'b1, 2'b10, 4'b0000};
      TMemAdr, TExecI: return {1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b01, 4'b0000};
      TMemRd, TMemWr:  return {1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 2'b00, 4'b0000};
      TMemWb:          return {1'b0, 1'b0, 3'b000, 2'b01, 1'b0, 2'b00, 4'b0000};
      TBranch:         return {1'b0, 1'b0, 3'b000, 2'b10, 1'b0, 2'b01, 4'b0000};
      default:         return 14'b0;  // TExecR, TAluWb
    endcase
  endfunction

  // Check one cycle's outputs against state s, then step to 1ns after the next edge.
  task automatic cyc(input string tag, input tst_e s, input logic pcw, input logic mw,
                     input logic rw, input logic [3:0] alu);
    logic [13:0] exp, m;
    exp = sel_of(s) | {pcw, 1'b0, mw, (s == TFetch), rw, 2'b00, 1'b0, 2'b00, alu};
    m   = care_of(s);
    #1;
    check(tag, {18'b0, ctl & m}, {18'b0, exp & m});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [19:0] ins, input logic [3:0] fl);
    Instr    = ins;
    ALUFlags = fl;
    cyc({tag, "/fetch"}, TFetch, 1'b1, 1'b0, 1'b0, 4'b0000);
    cyc({tag, "/decode"}, TDecode, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic dp(input string tag, input logic [19:0] ins, input logic [3:0] fl,
                    input logic imm, input logic [3:0] alu, input logic rw);
    fetch_decode(tag, ins, fl);
    cyc({tag, "/exec"}, imm ? TExecI : TExecR, 1'b0, 1'b0, 1'b0, alu);
    cyc({tag, "/aluwb"}, TAluWb, 1'b0, 1'b0, rw, 4'b0000);
  endtask

  task automatic br(input string tag, input logic [19:0] ins, input logic taken);
    fetch_decode(tag, ins, 4'b0000);
    cyc({tag, "/branch"}, TBranch, taken, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic str(input string tag, input logic [19:0] ins, input logic mw);
    fetch_decode(tag, ins, 4'b0000);
    cyc({tag, "/memadr"}, TMemAdr, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc({tag, "/memwr"}, TMemWr, 1'b0, mw, 1'b0, 4'b0000);
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 20'h0;
    ALUFlags = 4'h0;

    // Reset held three cycles: enables off, selects at FETCH values.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {18'b0, ctl}, {18'b0, RstVec});
    end
    reset = 1'b1;

    // ADDS: flags <- 0100, so the BEQ after it is taken.
    dp("adds", 20'hE0910, 4'b0100, 1'b0, 4'b0000, 1'b1);
    br("beq1", 20'h0A000, 1'b1);

    // CMP: SUB, no write-back, flags <- 0100; BEQ taken, BNE not.
    dp("cmp", 20'hE1500, 4'b0100, 1'b0, 4'b0001, 1'b0);
    br("beq2", 20'h0A000, 1'b1);
    check("br_immsrc", {30'b0, ImmSrc}, 32'd2);
    check("br_regsrc", {30'b0, RegSrc}, 32'd1);
    br("bne", 20'h1A000, 1'b0);

    // LDR: five cycles, write-back from memory data.
    fetch_decode("ldr", 20'hE5910, 4'b0000);
    check("ldr_immsrc", {30'b0, ImmSrc}, 32'd1);
    check("ldr_regsrc", {30'b0, RegSrc}, 32'd2);
    cyc("ldr/memadr", TMemAdr, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc("ldr/memrd", TMemRd, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc("ldr/memwb", TMemWb, 1'b0, 1'b0, 1'b1, 4'b0000);

    // STRNE with Z=1 is suppressed; STR AL writes.
    str("strne", 20'h15810, 1'b0);
    str("str", 20'hE5810, 1'b1);

    // ADDS sets C,V; ANDS then loads only N,Z -> flags 1011.
    dp("adds2", 20'hE0910, 4'b0011, 1'b0, 4'b0000, 1'b1);
    dp("ands", 20'hE0110, 4'b1000, 1'b0, 4'b0010, 1'b1);
    br("bcs", 20'h2A000, 1'b1);
    br("bvs", 20'h6A000, 1'b1);
    br("bmi", 20'h4A000, 1'b1);
    br("beq3", 20'h0A000, 1'b0);

    // ORR immediate without S, then unsupported cmd with S: neither touches flags.
    dp("orri", 20'hE3800, 4'b0100, 1'b1, 4'b0011, 1'b1);
    dp("eors", 20'hE0310, 4'b0100, 1'b0, 4'b0000, 1'b0);
    br("beq4", 20'h0A000, 1'b0);
    br("bne2", 20'h1A000, 1'b1);

    // Op=11: two cycles, straight back to FETCH.
    fetch_decode("nop", 20'hEC000, 4'b0000);

    // Reset asserted during MEMWR: store dropped, FETCH follows.
    fetch_decode("str_rst", 20'hE5810, 4'b0000);
    cyc("str_rst/memadr", TMemAdr, 1'b0, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;
    #1;
    check("str_rst/memwr", {18'b0, ctl}, {18'b0, RstVec});
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("after_rst/fetch", TFetch, 1'b1, 1'b0, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARM core: replaces the single-cycle decoder so that one unified instruction/data memory and one ALU can be shared across the cycles of each instruction. It receives the latched instruction fields and the ALU flags from the datapath. It drives every mux select, write enable and ALU operation through a Moore FSM, plus a small condition/flags unit. It sits beside the datapath in the core top, in the position the single-cycle controller occupies today.

## Interface
- No parameters; encodings come from `arm_mc_pkg`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low (0 = reset).
- `Instr` in 20: Instr[31:12] from the datapath instruction register; Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- `ALUFlags` in 4: {N,Z,C,V} of the current ALU result.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select, 0=PC, 1=ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select, 00=ALUOut, 01=Data, 10=ALUResult.
- `ALUSrcA` out 1: ALU A select, 0=RD1, 1=PC.
- `ALUSrcB` out 2: ALU B select, 00=RD2, 01=ExtImm, 10=constant 4.
- `ALUControl` out 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR.
- `ImmSrc` out 2: equals Op.
- `RegSrc` out 2: [0]=(Op==10), [1]=(Op==01).

## Operation
- States and transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for Op=01; EXECUTEI for Op=00 with Funct[5]=1; EXECUTER for Op=00 with Funct[5]=0; BRANCH for Op=10; FETCH for Op=11 (NOP).
  - MEMADR → MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECUTER/EXECUTEI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Outputs per state (unlisted enables 0, ALUControl=ADD):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8).
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl=decoded.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUControl=decoded.
  - ALUWB: ResultSrc=00, RegWrite=CondEx & !NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
- Data-processing decode on cmd=Instr[24:21]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP: SUB, NoWrite=1, S forced to 1.
  - Any other cmd: ADD, NoWrite=1, no flag update.
- CondEx is evaluated from Cond against the flags register and registered at the end of DECODE. Later states use only the registered value.
- Condition codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 → 0.
- Flag update happens at the end of EXECUTER/EXECUTEI, only if S (Funct[0]) and CondEx:
  - ADD/SUB/CMP load all four flags.
  - AND/ORR load N and Z only; C and V hold.

## Timing
- Cycles per instruction: DP 4, STR 4, LDR 5, B 3, Op=11 2.
- Register writes land on the edge that leaves MEMWB/ALUWB.
- The PC loads on the edge leaving FETCH, and on the edge leaving BRANCH when taken.
- While reset=0, every enable (PCWrite, IRWrite, RegWrite, MemWrite) is forced 0 combinationally and all selects are at their FETCH values.
- Reset values: state=FETCH, flags=0000, CondEx=0.
- Reset mid-instruction: the next edge returns to FETCH and any pending register or memory write is dropped.
- The first cycle after reset rises is FETCH.
- A flag-setting instruction followed by a conditional one: the second instruction's DECODE sees the updated flags.

## Structure
- `arm_mc_pkg` holds:
  - the state typedef enum (10 states);
  - the ALUControl, ResultSrc and ALUSrcB localparams;
  - the 4-bit condition-code constants.
- Sub-module `arm_condcheck` is combinational: Cond + flags → CondEx.
- The flags register, the CondEx register and the FSM live in `arm_mc_controller`.

## Test plan
- Reset held low for 3 cycles → all enables 0. The first cycle after release shows IRWrite=1, PCWrite=1, AdrSrc=0.
- ADDS with Instr[31:12]=E0910 → state sequence FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 in ALUWB. Flags take {N,Z,C,V} sampled in EXECUTER.
- CMP with ALUFlags=0100, then BEQ (Cond=0000) → BRANCH asserts PCWrite=1. A following BNE asserts PCWrite=0 and the FSM still returns to FETCH.
- LDR (Op=01, L=1) → MEMRD has AdrSrc=1. MEMWB has ResultSrc=01, RegWrite=1. Total 5 cycles.
- STRNE with Z=1 → MEMWR has MemWrite=0 and the FSM returns to FETCH on the next edge.
- reset driven low in MEMWR → MemWrite=0 in that cycle and state=FETCH after the edge. ANDS → C and V unchanged.
